// File: rtl/return_addr_stack.sv
// return_addr_stack
//   Speculative return-address stack for the fetch-stage-2 predecode.
//   Calls push callPC + INST_B and returns pop it. The top of stack is read
//   combinationally. One checkpoint {tos, count, topVal} is kept per CTI-queue
//   tag, and a mispredict restores it.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-low reset
//   stall_i        front-end stall; freezes push/pop/checkpoint
//   push_i         call detected
//   callPC_i       PC of the call instruction
//   pop_i          return detected
//   ckptEn_i       save checkpoint this cycle
//   ckptTag_i      checkpoint slot to write
//   recover_i      mispredict recovery; wins over stall and push/pop
//   recoverTag_i   checkpoint slot to restore
//   addrRAS_CP_o   stack[tos], combinational
//   empty_o        count == 0
//   full_o         count == DEPTH
//   overflow_o     one-cycle pulse: push while full (oldest entry lost)
//   underflow_o    one-cycle pulse: pop while empty

module return_addr_stack #(
    parameter int DEPTH  = 16,
    parameter int PC_W   = 32,
    parameter int TAG_W  = 3,
    parameter int INST_B = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             push_i,
    input  logic [PC_W-1:0]  callPC_i,
    input  logic             pop_i,
    input  logic             ckptEn_i,
    input  logic [TAG_W-1:0] ckptTag_i,
    input  logic             recover_i,
    input  logic [TAG_W-1:0] recoverTag_i,
    output logic [PC_W-1:0]  addrRAS_CP_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int NCKPT = 1 << TAG_W;

    logic [PC_W-1:0] stack     [DEPTH];
    logic [AW-1:0]   tos;
    logic [AW:0]     count;
    logic [AW-1:0]   ckptTos   [NCKPT];
    logic [AW:0]     ckptCount [NCKPT];
    logic [PC_W-1:0] ckptTop   [NCKPT];
    logic            overflowQ;
    logic            underflowQ;

    logic [AW-1:0]   nxtTos;
    logic [AW:0]     nxtCount;
    logic            wrEn;
    logic [AW-1:0]   wrAddr;
    logic [PC_W-1:0] wrData;
    logic            overflowNxt;
    logic            underflowNxt;
    logic            ckptWr;
    logic [PC_W-1:0] nxtTopVal;
    logic [PC_W-1:0] retAddr;
    logic            isFull;

    assign retAddr = callPC_i + PC_W'(INST_B);
    assign isFull  = (count == (AW+1)'(DEPTH));

    always_comb begin
        nxtTos       = tos;
        nxtCount     = count;
        wrEn         = 1'b0;
        wrAddr       = tos;
        wrData       = retAddr;
        overflowNxt  = 1'b0;
        underflowNxt = 1'b0;
        ckptWr       = 1'b0;

        if (recover_i) begin
            // Rewrite the checkpointed top entry: a wrong-path push may have
            // clobbered it even though tos itself is restored.
            nxtTos   = ckptTos[recoverTag_i];
            nxtCount = ckptCount[recoverTag_i];
            wrEn     = 1'b1;
            wrAddr   = ckptTos[recoverTag_i];
            wrData   = ckptTop[recoverTag_i];
        end else if (!stall_i) begin
            ckptWr = ckptEn_i;
            if (push_i && pop_i) begin
                // Return immediately followed by a call: replace top in place.
                wrEn     = 1'b1;
                wrAddr   = tos;
                nxtCount = (count == '0) ? (AW+1)'(1) : count;
            end else if (push_i) begin
                nxtTos = tos + 1'b1;
                wrEn   = 1'b1;
                wrAddr = tos + 1'b1;
                if (isFull) begin
                    overflowNxt = 1'b1;
                end else begin
                    nxtCount = count + 1'b1;
                end
            end else if (pop_i) begin
                if (count != '0) begin
                    nxtTos   = tos - 1'b1;
                    nxtCount = count - 1'b1;
                end else begin
                    underflowNxt = 1'b1;
                end
            end
        end
    end

    // Checkpoint captures the post-update top, including this cycle's write.
    assign nxtTopVal = (wrEn && (wrAddr == nxtTos)) ? wrData : stack[nxtTos];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack[i] <= '0;
            end
            for (int i = 0; i < NCKPT; i++) begin
                ckptTos[i]   <= '0;
                ckptCount[i] <= '0;
                ckptTop[i]   <= '0;
            end
            tos        <= '0;
            count      <= '0;
            overflowQ  <= 1'b0;
            underflowQ <= 1'b0;
        end else begin
            if (wrEn) begin
                stack[wrAddr] <= wrData;
            end
            if (ckptWr) begin
                ckptTos[ckptTag_i]   <= nxtTos;
                ckptCount[ckptTag_i] <= nxtCount;
                ckptTop[ckptTag_i]   <= nxtTopVal;
            end
            tos        <= nxtTos;
            count      <= nxtCount;
            overflowQ  <= overflowNxt;
            underflowQ <= underflowNxt;
        end
    end

    assign addrRAS_CP_o = stack[tos];
    assign empty_o      = (count == '0);
    assign full_o       = isFull;
    assign overflow_o   = overflowQ;
    assign underflow_o  = underflowQ;

endmodule
